// File: rtl/int_ctrl.sv
// int_ctrl: interrupt controller with flag (IF) and enable (IE) registers,
// a lowest-index-wins priority encoder, a delayed-EI master enable FSM and
// a registered dispatch vector.
//
// Ports
//   clk, reset     : system clock, asynchronous active-high reset
//   cpu_en         : clock enable; every register updates only when high
//   irq_req        : per-channel request pulses (set IF bits)
//   mem_addr/mem_wdata/write : CPU bus access to IF_ADDR / IE_ADDR
//   rdata, sel     : combinational read data and register-select flag
//   ei, di, reti   : instruction strobes controlling the master enable
//   instr_done     : instruction-boundary strobe (advances the EI delay)
//   int_pending    : any enabled flag set, regardless of master enable
//   int_take       : interrupt may be dispatched now
//   int_ack        : dispatch acknowledge
//   vector         : registered vector of the last dispatched channel
//   ime            : master enable
module int_ctrl #(
   parameter int          NUM_INTS   = 5,
   parameter logic [15:0] VEC_BASE   = 16'h0040,
   parameter int          VEC_STRIDE = 8,
   parameter logic [15:0] IF_ADDR    = 16'hFF0F,
   parameter logic [15:0] IE_ADDR    = 16'hFFFF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cpu_en,
   input  logic [NUM_INTS-1:0] irq_req,
   input  logic [15:0]         mem_addr,
   input  logic [7:0]          mem_wdata,
   input  logic                write,
   output logic [7:0]          rdata,
   output logic                sel,
   input  logic                ei,
   input  logic                di,
   input  logic                reti,
   input  logic                instr_done,
   output logic                int_pending,
   output logic                int_take,
   input  logic                int_ack,
   output logic [15:0]         vector,
   output logic                ime
);

   localparam int IDX_W = 3;

   typedef enum logic [1:0] {
      ST_DISABLED = 2'd0,
      ST_EI_WAIT1 = 2'd1,
      ST_EI_WAIT2 = 2'd2,
      ST_ENABLED  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [NUM_INTS-1:0] if_q, if_d;
   logic [NUM_INTS-1:0] ie_q, ie_d;
   logic [15:0]         vector_q, vector_d;

   logic [NUM_INTS-1:0] pend;
   logic [IDX_W-1:0]    win_idx;
   logic                dispatch;
   logic                if_sel, ie_sel, if_wr, ie_wr;
   logic [7:0]          if_ext, ie_ext;

   // Upper write-data bits only matter for configurations with 8 channels.
   logic unused_wdata;
   assign unused_wdata = &{1'b0, mem_wdata};

   assign if_sel = (mem_addr == IF_ADDR);
   assign ie_sel = (mem_addr == IE_ADDR);
   assign sel    = if_sel | ie_sel;
   assign if_wr  = write & if_sel;
   assign ie_wr  = write & ie_sel;

   assign pend        = if_q & ie_q;
   assign int_pending = |pend;
   assign dispatch    = int_ack & int_take;
   assign vector      = vector_q;

   // Lowest index wins: scan downward so the last hit is the smallest index.
   always_comb begin
      win_idx = '0;
      for (int i = NUM_INTS - 1; i >= 0; i--) begin
         if (pend[i]) win_idx = IDX_W'(i);
      end
   end

   // IF: dispatch clears the winner, a CPU write replaces the value, and
   // request pulses are OR-ed in last so a coincident request always wins.
   always_comb begin
      if_d = if_q;
      for (int i = 0; i < NUM_INTS; i++) begin
         if (dispatch && (win_idx == IDX_W'(i))) if_d[i] = 1'b0;
      end
      if (if_wr) if_d = mem_wdata[NUM_INTS-1:0];
      if_d = if_d | irq_req;
   end

   always_comb begin
      ie_d = ie_q;
      if (ie_wr) ie_d = mem_wdata[NUM_INTS-1:0];
   end

   // Vector arithmetic is deliberately 16-bit so it wraps around.
   always_comb begin
      vector_d = vector_q;
      if (dispatch) vector_d = VEC_BASE + 16'(win_idx) * 16'(VEC_STRIDE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         if_q     <= '0;
         ie_q     <= '0;
         vector_q <= VEC_BASE;
      end else if (cpu_en) begin
         if_q     <= if_d;
         ie_q     <= ie_d;
         vector_q <= vector_d;
      end
   end

   // Reads: unimplemented IF bits read as 1, unimplemented IE bits as 0.
   always_comb begin
      if_ext                 = 8'hFF;
      if_ext[NUM_INTS-1:0]   = if_q;
      ie_ext                 = 8'h00;
      ie_ext[NUM_INTS-1:0]   = ie_q;
      rdata                  = 8'h00;
      if (if_sel)      rdata = if_ext;
      else if (ie_sel) rdata = ie_ext;
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       state_q <= ST_DISABLED;
      else if (cpu_en) state_q <= state_d;
   end

   // FSM next state: dispatch and di force DISABLED, reti forces ENABLED,
   // otherwise EI walks through two instruction boundaries.
   always_comb begin
      state_d = state_q;
      if (dispatch || di) begin
         state_d = ST_DISABLED;
      end else if (reti) begin
         state_d = ST_ENABLED;
      end else begin
         case (state_q)
            ST_DISABLED: if (ei)         state_d = ST_EI_WAIT1;
            ST_EI_WAIT1: if (instr_done) state_d = ST_EI_WAIT2;
            ST_EI_WAIT2: if (instr_done) state_d = ST_ENABLED;
            default:                     state_d = state_q;
         endcase
      end
   end

   // FSM outputs
   always_comb begin
      ime      = (state_q == ST_ENABLED);
      int_take = ime & int_pending;
   end

endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;

   localparam int          N      = 5;
   localparam logic [15:0] IFA    = 16'hFF0F;
   localparam logic [15:0] IEA    = 16'hFFFF;
   localparam int          BASE   = 'h40;
   localparam int          STRIDE = 8;
   localparam int          MASK   = (1 << N) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main DUT (default parameters)
   logic         reset, cpu_en, write, ei, di, reti, instr_done, int_ack;
   logic [N-1:0] irq_req;
   logic [15:0]  mem_addr, vector;
   logic [7:0]   mem_wdata, rdata;
   logic         sel, int_pending, int_take, ime;

   int_ctrl u_dut (
      .clk(clk), .reset(reset), .cpu_en(cpu_en), .irq_req(irq_req),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .write(write),
      .rdata(rdata), .sel(sel), .ei(ei), .di(di), .reti(reti),
      .instr_done(instr_done), .int_pending(int_pending), .int_take(int_take),
      .int_ack(int_ack), .vector(vector), .ime(ime)
   );

   // 8-channel DUT for the vector wrap-around case
   logic         b_reset, b_cpu_en, b_write, b_ei, b_di, b_reti, b_instr_done, b_int_ack;
   logic [7:0]   b_irq_req, b_wdata, b_rdata;
   logic [15:0]  b_addr, b_vector;
   logic         b_sel, b_int_pending, b_int_take, b_ime;

   int_ctrl #(.NUM_INTS(8), .VEC_BASE(16'hFFF8), .VEC_STRIDE(8)) u_dut8 (
      .clk(clk), .reset(b_reset), .cpu_en(b_cpu_en), .irq_req(b_irq_req),
      .mem_addr(b_addr), .mem_wdata(b_wdata), .write(b_write),
      .rdata(b_rdata), .sel(b_sel), .ei(b_ei), .di(b_di), .reti(b_reti),
      .instr_done(b_instr_done), .int_pending(b_int_pending), .int_take(b_int_take),
      .int_ack(b_int_ack), .vector(b_vector), .ime(b_ime)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: flags/enables as integers, master enable as a flag
   // plus a count of instruction boundaries still to wait after EI.
   int m_if, m_ie, m_wait, m_vec;
   bit m_ime;

   function automatic int lowest(input int v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic m_reset();
      m_if = 0; m_ie = 0; m_wait = 0; m_vec = BASE; m_ime = 1'b0;
   endtask

   task automatic clear_in();
      cpu_en = 1'b1; write = 1'b0; ei = 1'b0; di = 1'b0; reti = 1'b0;
      instr_done = 1'b0; int_ack = 1'b0; irq_req = '0; mem_addr = 16'h0000;
      mem_wdata = 8'h00;
   endtask

   // Called just after a falling edge with inputs driven; checks outputs,
   // advances the model across the rising edge, then clears the strobes.
   task automatic tick();
      int  n_if, n_ie, n_wait, n_vec, k, exp_rd;
      bit  n_ime, take, pend;
      #1;
      pend = ((m_if & m_ie) != 0);
      take = m_ime && pend;
      if (mem_addr == IFA)      exp_rd = ((255 << N) & 255) | m_if;
      else if (mem_addr == IEA) exp_rd = m_ie;
      else                      exp_rd = 0;
      check_val("sel", 32'(sel), 32'((mem_addr == IFA) || (mem_addr == IEA)));
      check_val("rdata", 32'(rdata), 32'(exp_rd));
      check_val("int_pending", 32'(int_pending), 32'(pend));
      check_val("int_take", 32'(int_take), 32'(take));
      check_val("ime", 32'(ime), 32'(m_ime));
      check_val("vector", 32'(vector), 32'(m_vec));
      n_if = m_if; n_ie = m_ie; n_ime = m_ime; n_wait = m_wait; n_vec = m_vec;
      if (cpu_en) begin
         if (write && mem_addr == IEA) n_ie = mem_wdata & MASK;
         if (int_ack && take) begin
            k = lowest(m_if & m_ie);
            n_vec = (BASE + k * STRIDE) % 65536;
            n_if = n_if & ~(1 << k);
            n_ime = 1'b0; n_wait = 0;
         end else if (di) begin
            n_ime = 1'b0; n_wait = 0;
         end else if (reti) begin
            n_ime = 1'b1; n_wait = 0;
         end else if (ei && !m_ime && m_wait == 0) begin
            n_wait = 2;
         end else if (instr_done && m_wait > 0) begin
            n_wait = m_wait - 1;
            if (n_wait == 0) n_ime = 1'b1;
         end
         if (write && mem_addr == IFA) n_if = mem_wdata & MASK;
         n_if = n_if | int'(irq_req);
      end
      @(posedge clk);
      m_if = n_if; m_ie = n_ie; m_ime = n_ime; m_wait = n_wait; m_vec = n_vec;
      @(negedge clk);
      clear_in();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      mem_addr = IFA;
      #1;
      check_val("rst_ime", 32'(ime), 32'd0);
      check_val("rst_take", 32'(int_take), 32'd0);
      check_val("rst_pend", 32'(int_pending), 32'd0);
      check_val("rst_vector", 32'(vector), 32'(BASE));
      check_val("rst_if_rd", 32'(rdata), 32'hE0);
      mem_addr = IEA;
      #1;
      check_val("rst_ie_rd", 32'(rdata), 32'h00);
      m_reset();
      @(negedge clk);
      reset = 1'b0;
      clear_in();
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      mem_addr = a; mem_wdata = d; write = 1'b1;
      tick();
   endtask

   initial begin
      reset = 1'b1;
      clear_in();
      b_reset = 1'b1; b_cpu_en = 1'b1; b_write = 1'b0; b_ei = 1'b0; b_di = 1'b0;
      b_reti = 1'b0; b_instr_done = 1'b0; b_int_ack = 1'b0; b_irq_req = '0;
      b_addr = 16'h0000; b_wdata = 8'h00;
      m_reset();
      @(negedge clk);

      // 8-channel wrap-around vector
      b_reset = 1'b0;
      #1 check_val("w8_rst_vector", 32'(b_vector), 32'hFFF8);
      b_addr = 16'hFF0F; b_wdata = 8'h80; b_write = 1'b1;
      @(negedge clk);
      b_addr = 16'hFFFF;
      @(negedge clk);
      b_write = 1'b0; b_reti = 1'b1;
      @(negedge clk);
      b_reti = 1'b0;
      #1 check_val("w8_take", 32'(b_int_take), 32'd1);
      b_int_ack = 1'b1;
      @(negedge clk);
      b_int_ack = 1'b0; b_addr = 16'hFF0F;
      #1;
      check_val("w8_vector", 32'(b_vector), 32'h0030);
      check_val("w8_ime", 32'(b_ime), 32'd0);
      check_val("w8_if_rd", 32'(b_rdata), 32'h00);

      // Default-parameter basic flow with delayed EI
      do_reset();
      wr(IEA, 8'h1F);
      irq_req = 5'b00100; tick();
      ei = 1'b1; tick();
      instr_done = 1'b1; tick();
      #1 check_val("ei_wait_ime", 32'(ime), 32'd0);
      instr_done = 1'b1; tick();
      #1 check_val("ei_done_ime", 32'(ime), 32'd1);
      int_ack = 1'b1; tick();
      mem_addr = IFA;
      #1;
      check_val("basic_vector", 32'(vector), 32'h0050);
      check_val("basic_if_rd", 32'(rdata), 32'hE0);
      check_val("basic_ime", 32'(ime), 32'd0);
      tick();

      // Priority: lowest enabled pending index wins
      do_reset();
      wr(IFA, 8'h16);
      wr(IEA, 8'h14);
      reti = 1'b1; tick();
      int_ack = 1'b1; tick();
      mem_addr = IFA;
      #1;
      check_val("prio_vector", 32'(vector), 32'h0050);
      check_val("prio_if_rd", 32'(rdata), 32'hF2);
      tick();

      // EI cancelled by DI before any instruction boundary
      do_reset();
      wr(IFA, 8'h01);
      wr(IEA, 8'h01);
      ei = 1'b1; tick();
      di = 1'b1; tick();
      for (int i = 0; i < 3; i++) begin
         instr_done = 1'b1; tick();
         #1 check_val("ei_di_take", 32'(int_take), 32'd0);
      end

      // Request coincident with the dispatch that clears it
      do_reset();
      wr(IFA, 8'h01);
      wr(IEA, 8'h01);
      reti = 1'b1; tick();
      int_ack = 1'b1; irq_req = 5'b00001; tick();
      mem_addr = IFA;
      #1;
      check_val("coinc_vector", 32'(vector), 32'h0040);
      check_val("coinc_if_rd", 32'(rdata), 32'hE1);
      tick();

      // Asynchronous reset in EI_WAIT2
      do_reset();
      wr(IEA, 8'h1F);
      wr(IFA, 8'h1F);
      ei = 1'b1; tick();
      instr_done = 1'b1; tick();
      do_reset();

      // Randomized traffic against the model
      for (int it = 0; it < 600; it++) begin
         int r, st;
         if (it % 150 == 149) do_reset();
         cpu_en = ($urandom % 8) != 0;
         r = $urandom % 4;
         mem_addr = (r == 0) ? IFA : (r == 1) ? IEA : (r == 2) ? 16'($urandom) : 16'h0000;
         mem_wdata = 8'($urandom);
         write = ($urandom % 3) == 0;
         irq_req = (($urandom % 4) == 0) ? N'($urandom) : '0;
         int_ack = ($urandom % 3) == 0;
         instr_done = ($urandom % 3) == 0;
         st = $urandom % 8;
         ei = (st == 0) && !int_ack;
         di = (st == 1);
         reti = (st == 2) && !int_ack;
         if (int_ack) write = 1'b0;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter NUM_INTS, default 5; number of interrupt channels, legal range 1..8.
REQ-002 Parameter VEC_BASE, default 16'h0040; vector of channel 0.
REQ-003 Parameter VEC_STRIDE, default 8; vector spacing between channels.
REQ-004 Parameter IF_ADDR, default 16'hFF0F; flag register address.
REQ-005 Parameter IE_ADDR, default 16'hFFFF; enable register address.
REQ-006 clk  in  1  system clock; the block has one clock.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 cpu_en  in  1  clock enable; all state updates SHALL occur only on clk edges with cpu_en=1.
REQ-009 irq_req  in  NUM_INTS  per-channel request pulses from peripherals.
REQ-010 mem_addr  in  16  CPU bus address.
REQ-011 mem_wdata  in  8  CPU write data.
REQ-012 write  in  1  CPU write strobe.
REQ-013 rdata  out  8  read data for IF/IE; 8'h00 when no register is selected.
REQ-014 sel  out  1  combinational; high when mem_addr equals IF_ADDR or IE_ADDR.
REQ-015 ei, di, reti  in  1 each  instruction strobes from the controller.
REQ-016 instr_done  in  1  instruction-boundary strobe.
REQ-017 int_pending  out  1  combinational OR of (IF & IE), independent of IME; used for HALT wake.
REQ-018 int_take  out  1  combinational; high when IME=1, int_pending=1 and state is ENABLED.
REQ-019 int_ack  in  1  dispatch acknowledge from the controller.
REQ-020 vector  out  16  registered dispatch vector.
REQ-021 ime  out  1  high in state ENABLED only.

Function
REQ-022 IF SHALL be NUM_INTS bits; a bit is set by an irq_req pulse or by a write to IF_ADDR, and cleared by a write or by dispatch.
REQ-023 On an IF write cycle, next IF SHALL be (mem_wdata[NUM_INTS-1:0] | irq_req); set wins.
REQ-024 IE SHALL be NUM_INTS bits, loaded from mem_wdata on a write to IE_ADDR.
REQ-025 An IF read SHALL return 1 in bits 7..NUM_INTS; an IE read SHALL return 0 in those bits.
REQ-026 Channel priority: the lowest index SHALL win.
REQ-027 FSM states: DISABLED, EI_WAIT1, EI_WAIT2, ENABLED.
REQ-028 ei in DISABLED -> EI_WAIT1; EI_WAIT1 -> EI_WAIT2 on instr_done; EI_WAIT2 -> ENABLED on instr_done. IME therefore becomes set after the instruction following EI.
REQ-029 ei in ENABLED or in either wait state SHALL cause no state change.
REQ-030 di in any state -> DISABLED in the same cycle; di has priority over instr_done.
REQ-031 reti in any state -> ENABLED immediately, with no delay.
REQ-032 int_ack while int_take=1:
- latch the winning index k;
- vector <= VEC_BASE + k*VEC_STRIDE, computed in 16 bits with wrap-around;
- clear IF[k];
- state -> DISABLED;
- all of the above in one cycle; vector is valid from the next cycle.
REQ-033 If irq_req[k] pulses in the same cycle that dispatch clears IF[k], IF[k] SHALL remain 1.
REQ-034 int_ack while int_take=0 SHALL be ignored; IF, state and vector are unchanged.
REQ-035 If int_ack and di occur together, dispatch SHALL occur; the final state is DISABLED.
REQ-036 With cpu_en=0, all registers SHALL hold; combinational outputs still follow the held state.

Reset
REQ-037 While reset=1: IF=0, IE=0, state=DISABLED, vector=VEC_BASE, ime=0, int_take=0, int_pending=0.
REQ-038 Reset asserted mid-dispatch or mid-EI_WAIT SHALL abort the operation and return to the REQ-037 values without waiting for a clock edge.

Verification
REQ-039 Defaults: write IE=8'h1F, pulse irq_req=5'b00100, ei, then instr_done x2, then int_ack -> ime=1 after the 2nd instr_done; after ack vector=16'h0050, IF=0, ime=0.
REQ-040 IF=5'b10110, IE=5'b10100, ENABLED, int_ack -> vector=16'h0050; IF read=8'hF2.
REQ-041 In DISABLED: pulse ei then di before any instr_done -> state DISABLED; int_take stays 0 through later instr_done strobes.
REQ-042 IF=5'b00001, IE=5'b00001, int_ack coincident with irq_req[0] -> vector=16'h0040; IF[0] remains 1.
REQ-043 NUM_INTS=8, VEC_BASE=16'hFFF8, VEC_STRIDE=8, IF=IE=8'h80, ENABLED, int_ack -> vector=16'h0030 (wrap-around).
REQ-044 reset pulsed during EI_WAIT2 with IF=IE=5'h1F -> ime=0, int_pending=0, IF read=8'hE0.
